// File: rtl/ofm_write_sequencer.sv
// ---------------------------------------------------------------------------
// ofm_write_sequencer
//
// Purpose:
//   Sequences the output-feature-map (OFM) writes of one convolution layer.
//   Filters are processed in groups of SYSTOLIC_SIZE columns. Each group is
//   written as tiles_per_group row-segment tiles. A tile is written as one
//   channel per cycle for read_wgt_size cycles, so every tile write takes
//   read_wgt_size wr_en cycles.
//
// Ports:
//   clk              : single clock, all logic on posedge
//   rst              : synchronous active-high reset
//   layer_start      : one-cycle pulse, begin a layer (accepted only when idle)
//   layer_base_addr  : OFM start address of the layer
//   num_filter       : filters in the layer (0..1023)
//   tiles_per_group  : row-segment tile writes per filter group
//   tile_valid       : array result tile available
//   tile_ready       : one-cycle pulse, tile consumed
//   start            : one-cycle pulse to the OFM address controller
//   start_write_addr : latched copy of layer_base_addr
//   write            : one-cycle pulse, begin one tile write
//   read_wgt_size    : filters in the current group (1..SYSTOLIC_SIZE)
//   count_filter     : index of the current filter group
//   wr_en            : OFM RAM write enable, one channel per cycle
//   wr_channel       : channel within group being written
//   busy             : layer in progress
//   layer_done       : one-cycle pulse, layer complete
//   stall_cycles     : (only with OFM_WRITE_SEQ_PERF_EN) cycles spent waiting
//                      for a tile while busy
//
// Build option:
//   OFM_WRITE_SEQ_PERF_EN : adds the stall_cycles performance counter.
// ---------------------------------------------------------------------------
module ofm_write_sequencer #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_RAM_SIZE  = 2205619,
    localparam int AW           = $clog2(OFM_RAM_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          layer_start,
    input  logic [AW-1:0] layer_base_addr,
    input  logic [9:0]    num_filter,
    input  logic [15:0]   tiles_per_group,
    input  logic          tile_valid,
    output logic          tile_ready,
    output logic          start,
    output logic [AW-1:0] start_write_addr,
    output logic          write,
    output logic [4:0]    read_wgt_size,
    output logic [6:0]    count_filter,
    output logic          wr_en,
    output logic [4:0]    wr_channel,
    output logic          busy,
    output logic          layer_done
`ifdef OFM_WRITE_SEQ_PERF_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INIT       = 3'd1,
        WAIT_TILE  = 3'd2,
        WRITE      = 3'd3,
        GAP        = 3'd4,
        NEXT_GROUP = 3'd5,
        DONE       = 3'd6
    } state_t;

    localparam logic [9:0]  SS10 = 10'(SYSTOLIC_SIZE);
    localparam logic [4:0]  SS5  = 5'(SYSTOLIC_SIZE);
    localparam logic [10:0] SS11 = 11'(SYSTOLIC_SIZE);

    state_t        r_state;
    state_t        w_next_state;

    logic [9:0]    r_num_filter;
    logic [15:0]   r_tiles_per_group;
    logic [AW-1:0] r_base_addr;
    logic [6:0]    r_groups;
    logic [6:0]    r_count_filter;
    logic [4:0]    r_read_wgt_size;
    logic [15:0]   r_tile_cnt;
    logic [4:0]    r_wr_channel;

    logic          w_start;
    logic          w_write;
    logic          w_wr_en;
    logic          w_done;
    logic          w_busy;
    logic [6:0]    w_groups;
    logic [4:0]    w_first_size;
    logic [6:0]    w_cf_next;
    logic [9:0]    w_group_base;
    logic [4:0]    w_remainder;
    logic          w_next_is_last;
    logic [15:0]   w_tile_inc;

    // ceil(num_filter / SYSTOLIC_SIZE); divisor is a constant
    assign w_groups     = 7'((11'(num_filter) + SS11 - 11'd1) / SS11);
    assign w_first_size = (num_filter > SS10) ? SS5 : num_filter[4:0];

    // Last group carries the leftover filters; the 10-bit difference is at
    // most SYSTOLIC_SIZE so truncating to 5 bits is lossless.
    assign w_cf_next      = r_count_filter + 7'd1;
    assign w_group_base   = 10'(w_cf_next) * SS10;
    assign w_remainder    = 5'(r_num_filter - w_group_base);
    assign w_next_is_last = (w_cf_next == (r_groups - 7'd1));
    assign w_tile_inc     = r_tile_cnt + 16'd1;

    // Next-state and per-state strobes; write/tile_ready are combinational on
    // tile_valid so the tile is taken in the very cycle it is offered.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_write      = 1'b0;
        w_wr_en      = 1'b0;
        w_done       = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (layer_start) begin
                    w_next_state = INIT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            INIT: begin
                w_start = 1'b1;
                w_busy  = 1'b1;
                if ((r_num_filter == 10'd0) || (r_tiles_per_group == 16'd0)) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = WAIT_TILE;
                end
            end
            WAIT_TILE: begin
                w_busy = 1'b1;
                if (tile_valid) begin
                    w_write      = 1'b1;
                    w_next_state = WRITE;
                end else begin
                    w_next_state = WAIT_TILE;
                end
            end
            WRITE: begin
                w_busy  = 1'b1;
                w_wr_en = 1'b1;
                if (r_wr_channel == (r_read_wgt_size - 5'd1)) begin
                    w_next_state = GAP;
                end else begin
                    w_next_state = WRITE;
                end
            end
            GAP: begin
                w_busy = 1'b1;
                if (w_tile_inc < r_tiles_per_group) begin
                    w_next_state = WAIT_TILE;
                end else if (r_count_filter < (r_groups - 7'd1)) begin
                    w_next_state = NEXT_GROUP;
                end else begin
                    w_next_state = DONE;
                end
            end
            NEXT_GROUP: begin
                w_busy       = 1'b1;
                w_next_state = WAIT_TILE;
            end
            DONE: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched layer configuration and group/tile/channel counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_filter      <= 10'd0;
            r_tiles_per_group <= 16'd0;
            r_base_addr       <= '0;
            r_groups          <= 7'd0;
            r_count_filter    <= 7'd0;
            r_read_wgt_size   <= 5'd0;
            r_tile_cnt        <= 16'd0;
            r_wr_channel      <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (layer_start) begin
                        r_num_filter      <= num_filter;
                        r_tiles_per_group <= tiles_per_group;
                        r_base_addr       <= layer_base_addr;
                        r_groups          <= w_groups;
                        r_count_filter    <= 7'd0;
                        r_read_wgt_size   <= w_first_size;
                        r_tile_cnt        <= 16'd0;
                        r_wr_channel      <= 5'd0;
                    end
                end
                WAIT_TILE: begin
                    r_wr_channel <= 5'd0;
                end
                WRITE: begin
                    if (r_wr_channel == (r_read_wgt_size - 5'd1)) begin
                        r_wr_channel <= 5'd0;
                    end else begin
                        r_wr_channel <= r_wr_channel + 5'd1;
                    end
                end
                GAP: begin
                    r_tile_cnt <= w_tile_inc;
                end
                NEXT_GROUP: begin
                    r_count_filter <= w_cf_next;
                    r_tile_cnt     <= 16'd0;
                    if (w_next_is_last) begin
                        r_read_wgt_size <= w_remainder;
                    end else begin
                        r_read_wgt_size <= SS5;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef OFM_WRITE_SEQ_PERF_EN
    logic [31:0] r_stall_cycles;

    // Stall counter: cycles a busy sequencer waits without a tile offered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
        end else if ((r_state == IDLE) && layer_start) begin
            r_stall_cycles <= 32'd0;
        end else if ((r_state == WAIT_TILE) && !tile_valid) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign start            = w_start;
    assign write            = w_write;
    assign tile_ready       = w_write;
    assign wr_en            = w_wr_en;
    assign layer_done       = w_done;
    assign busy             = w_busy;
    assign start_write_addr = r_base_addr;
    assign read_wgt_size    = r_read_wgt_size;
    assign count_filter     = r_count_filter;
    assign wr_channel       = r_wr_channel;

endmodule
